// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory read port between
// the fetch (f_*) and load (l_*) requesters, with a timeout on a missing RVld.
module mem_read_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_vld,
    output logic [DW-1:0] f_data,
    output logic          f_err,
    input  logic          l_req,
    input  logic [AW-1:0] l_addr,
    output logic          l_gnt,
    output logic          l_vld,
    output logic [DW-1:0] l_data,
    output logic          l_err,
    output logic          RRdy,
    output logic [AW-1:0] RAddr,
    input  logic          RVld,
    input  logic [DW-1:0] RData
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {REQ_F = 1'b0, REQ_L = 1'b1} req_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t        state, state_nx;
    req_t          owner, owner_nx, last, last_nx, win;
    logic [7:0]    cnt, cnt_nx;
    logic          rrdy_nx, f_gnt_nx, l_gnt_nx, f_vld_nx, l_vld_nx, f_err_nx, l_err_nx;
    logic [AW-1:0] raddr_nx;
    logic [DW-1:0] f_data_nx, l_data_nx;

    always_ff @(posedge clk) begin
        if (rstn) begin
            state  <= IDLE;
            owner  <= REQ_F;
            last   <= REQ_L;
            cnt    <= '0;
            RRdy   <= 1'b0;
            RAddr  <= '0;
            f_gnt  <= 1'b0;
            l_gnt  <= 1'b0;
            f_vld  <= 1'b0;
            l_vld  <= 1'b0;
            f_err  <= 1'b0;
            l_err  <= 1'b0;
            f_data <= '0;
            l_data <= '0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            last   <= last_nx;
            cnt    <= cnt_nx;
            RRdy   <= rrdy_nx;
            RAddr  <= raddr_nx;
            f_gnt  <= f_gnt_nx;
            l_gnt  <= l_gnt_nx;
            f_vld  <= f_vld_nx;
            l_vld  <= l_vld_nx;
            f_err  <= f_err_nx;
            l_err  <= l_err_nx;
            f_data <= f_data_nx;
            l_data <= l_data_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        last_nx   = last;
        cnt_nx    = cnt;
        raddr_nx  = RAddr;
        f_data_nx = f_data;
        l_data_nx = l_data;
        rrdy_nx   = 1'b0;
        f_gnt_nx  = 1'b0;
        l_gnt_nx  = 1'b0;
        f_vld_nx  = 1'b0;
        l_vld_nx  = 1'b0;
        f_err_nx  = 1'b0;
        l_err_nx  = 1'b0;
        // On a tie the requester that did not win last time gets the port.
        if (f_req && l_req) win = (last == REQ_F) ? REQ_L : REQ_F;
        else                win = f_req ? REQ_F : REQ_L;

        case (state)
            IDLE: begin
                if (en && (f_req || l_req)) begin
                    raddr_nx = (win == REQ_F) ? f_addr : l_addr;
                    rrdy_nx  = 1'b1;
                    f_gnt_nx = (win == REQ_F);
                    l_gnt_nx = (win == REQ_L);
                    owner_nx = win;
                    last_nx  = win;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nx   = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                if (RVld) begin
                    if (owner == REQ_F) begin
                        f_data_nx = RData;
                        f_vld_nx  = 1'b1;
                    end else begin
                        l_data_nx = RData;
                        l_vld_nx  = 1'b1;
                    end
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    f_err_nx = (owner == REQ_F);
                    l_err_nx = (owner == REQ_L);
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: vector table for single grants, scoreboard of
// expected responses, and hand sequences for round-robin, timeout, gating, reset.
module tb_mem_read_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          en = 1'b0;
    logic          f_req = 1'b0, l_req = 1'b0;
    logic [AW-1:0] f_addr = '0, l_addr = '0;
    logic          f_gnt, f_vld, f_err, l_gnt, l_vld, l_err, RRdy;
    logic [DW-1:0] f_data, l_data;
    logic [AW-1:0] RAddr;
    logic          RVld = 1'b0;
    logic [DW-1:0] RData = '0;

    mem_read_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_vld(f_vld), .f_data(f_data), .f_err(f_err),
        .l_req(l_req), .l_addr(l_addr), .l_gnt(l_gnt), .l_vld(l_vld), .l_data(l_data), .l_err(l_err),
        .RRdy(RRdy), .RAddr(RAddr), .RVld(RVld), .RData(RData)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [256];
    logic          mute = 1'b0;

    // Memory model: answers one cycle after the read strobe unless muted.
    always @(posedge clk) begin
        RVld <= RRdy && !mute;
        if (RRdy) RData <= mem[RAddr[7:0]];
    end

    typedef struct packed {
        logic          load;
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct packed {
        logic          en;
        logic          fr;
        logic          lr;
        logic [AW-1:0] fa;
        logic [AW-1:0] la;
        logic          exp_grant;
        logic          exp_load;
        logic [AW-1:0] exp_addr;
    } vec_t;

    rsp_t          sb[$];
    vec_t          vecs[9];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mf = '0, ml = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic load, input logic err, input logic [AW-1:0] addr);
        rsp_t e;
        e.load = load;
        e.err  = err;
        e.data = err ? (load ? ml : mf) : mem[addr[7:0]];
        if (!err) begin
            if (load) ml = e.data;
            else      mf = e.data;
        end
        sb.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops the scoreboard on every vld/err pulse.
    always @(negedge clk) begin
        int n;
        n = int'(f_vld) + int'(l_vld) + int'(f_err) + int'(l_err) + int'(RRdy);
        if (n > 1) chk("overlap", n, 1);
        if (f_vld || l_vld || f_err || l_err) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp act=%b%b%b%b exp=none", f_vld, l_vld, f_err, l_err);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_owner", 32'(l_vld | l_err), 32'(e.load));
                chk("rsp_err", 32'(f_err | l_err), 32'(e.err));
                chk("rsp_data", e.load ? l_data : f_data, e.data);
            end
        end
    end

    task automatic do_reset;
        rstn = 1'b1;
        f_req = 1'b0;
        l_req = 1'b0;
        repeat (3) tick();
        chk("rst_pulses", 32'({f_gnt, f_vld, f_err, l_gnt, l_vld, l_err, RRdy}), 32'd0);
        chk("rst_fdata", f_data, 32'd0);
        chk("rst_ldata", l_data, 32'd0);
        chk("rst_raddr", RAddr, 32'd0);
        mf = '0;
        ml = '0;
        rstn = 1'b0;
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        en = v.en;
        f_req = v.fr;
        l_req = v.lr;
        f_addr = v.fa;
        l_addr = v.la;
        if (v.exp_grant) push(v.exp_load, 1'b0, v.exp_addr);
        tick();
        chk("vec_rrdy", 32'(RRdy), 32'(v.exp_grant));
        chk("vec_fgnt", 32'(f_gnt), 32'(v.exp_grant & ~v.exp_load));
        chk("vec_lgnt", 32'(l_gnt), 32'(v.exp_grant & v.exp_load));
        if (v.exp_grant) chk("vec_raddr", RAddr, v.exp_addr);
        f_req = 1'b0;
        l_req = 1'b0;
        en = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        int k;
        logic got;
        for (int i = 0; i < 256; i++) mem[i] = {24'hC0FFEE, 8'(i)} ^ (32'(i) << 12);
        mem[4] = 32'h0000_00A3;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h04, 32'h00, 1'b1, 1'b0, 32'h04};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h10, 32'h20, 1'b1, 1'b1, 32'h20};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h10, 32'h20, 1'b1, 1'b0, 32'h10};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h00, 32'h30, 1'b1, 1'b1, 32'h30};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h00, 32'h34, 1'b1, 1'b1, 32'h34};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h40, 32'h44, 1'b1, 1'b0, 32'h40};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h48, 32'h4C, 1'b0, 1'b0, 32'h00};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h08, 32'h00, 1'b1, 1'b0, 32'h08};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 32'h0C, 32'hC0, 1'b1, 1'b1, 32'hC0};

        // Reset, then idle with no requests.
        do_reset();
        en = 1'b1;
        k = 0;
        repeat (20) begin
            tick();
            if (RRdy) k++;
        end
        chk("idle_rrdy", k, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Held tie after reset: F,L,F,L, one strobe every 3 cycles.
        do_reset();
        en = 1'b1;
        f_addr = 32'h10;
        l_addr = 32'h20;
        push(1'b0, 1'b0, 32'h10);
        push(1'b1, 1'b0, 32'h20);
        push(1'b0, 1'b0, 32'h10);
        push(1'b1, 1'b0, 32'h20);
        f_req = 1'b1;
        l_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("rr_rrdy", 32'(RRdy), 32'(i % 3 == 1));
            if (i % 3 == 1) begin
                chk("rr_raddr", RAddr, ((i / 3) % 2 == 0) ? 32'h10 : 32'h20);
                chk("rr_lgnt", 32'(l_gnt), 32'((i / 3) % 2));
            end
            if (i == 10) begin
                f_req = 1'b0;
                l_req = 1'b0;
            end
        end
        repeat (2) tick();

        // Timeout: memory never answers.
        mute = 1'b1;
        push(1'b1, 1'b1, 32'h50);
        l_req = 1'b1;
        l_addr = 32'h50;
        k = 0;
        got = 1'b0;
        while (k < 40 && !got) begin
            tick();
            k++;
            if (k == 1) l_req = 1'b0;
            if (l_err) got = 1'b1;
        end
        chk("timeout_lat", k, 2 + TIMEOUT);
        mute = 1'b0;
        tick();
        run_vec(vecs[3]);

        // Gating: en=0 blocks grants; dropping en in flight still delivers.
        en = 1'b0;
        f_req = 1'b1;
        f_addr = 32'h60;
        k = 0;
        repeat (5) begin
            tick();
            if (RRdy || f_gnt) k++;
        end
        chk("gate_nogrant", k, 0);
        push(1'b0, 1'b0, 32'h60);
        en = 1'b1;
        tick();
        chk("gate_rrdy", 32'(RRdy), 32'd1);
        chk("gate_raddr", RAddr, 32'h60);
        f_req = 1'b0;
        en = 1'b0;
        repeat (2) tick();
        chk("gate_fvld", 32'(f_vld), 32'd1);
        tick();
        en = 1'b1;

        // Reset in the WAIT cycle where RVld is high: no response.
        f_req = 1'b1;
        f_addr = 32'h70;
        tick();
        f_req = 1'b0;
        tick();
        chk("midrst_rvld", 32'(RVld), 32'd1);
        rstn = 1'b1;
        tick();
        chk("midrst_out", 32'({f_gnt, f_vld, f_err, l_gnt, l_vld, l_err, RRdy}), 32'd0);
        chk("midrst_data", f_data, 32'd0);
        mf = '0;
        ml = '0;
        rstn = 1'b0;
        repeat (4) tick();

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
